// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory access controller.
// Holds FSM states, rv32i load/store funct3 codes and the request bundle.
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } dmem_ctrl_state_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  // Access size lives in funct3[1:0] for both loads and stores.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
  } dmem_req_t;

  function automatic logic [31:0] word_addr(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane alignment: funct3/addr/store_data -> mbe, shifted wdata, misaligned.
// Purely combinational; misaligned here is ungated (caller qualifies it).
module dmem_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [3:0]  mbe,
  output logic [31:0] wdata,
  output logic        misaligned
);

  logic [1:0] a;
  assign a = addr[1:0];

  // Sign/zero choice and upper address bits do not affect lanes.
  logic unused_bits;
  assign unused_bits = ^{funct3[2], addr[31:2]};

  always_comb begin
    mbe        = 4'b0000;
    misaligned = 1'b0;
    unique case (funct3[1:0])
      SZ_B: begin
        mbe = 4'b0001 << a;
      end
      SZ_H: begin
        mbe        = 4'b0011 << a;
        misaligned = a[0];
      end
      SZ_W: begin
        mbe        = 4'b1111;
        misaligned = |a;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  assign wdata = store_data << {a, 3'b000};

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer: one held cache request per access,
// pipeline stall until dmem_resp, raw read word + mask capture, timeout flag.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        advance,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_stall,
  output logic [31:0] rdata_out,
  output logic [3:0]  mbe_out,
  output logic        misaligned,
  output logic        timeout_err
);

  import dmem_access_ctrl_pkg::*;

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam bit T_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] T_LAST =
    CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  dmem_ctrl_state_t state;
  dmem_req_t        req;
  logic [CW-1:0]    tcnt;

  logic [3:0]  al_mbe;
  logic [31:0] al_wdata;
  logic        al_mis;
  logic        mem_op;
  logic        acc;

  dmem_align u_align (
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mbe        (al_mbe),
    .wdata      (al_wdata),
    .misaligned (al_mis)
  );

  assign mem_op     = valid_in & (load | store);
  assign misaligned = mem_op & al_mis;
  assign acc        = mem_op & ~al_mis;

  assign mem_stall = (state == BUSY) |
                     ((state == IDLE) & acc);

  assign dmem_read    = req.rd;
  assign dmem_write   = req.wr;
  assign dmem_address = req.addr;
  assign dmem_wdata   = req.wdata;
  assign dmem_mbe     = req.mbe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req         <= '0;
      rdata_out   <= '0;
      mbe_out     <= '0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tcnt <= '0;
          if (acc) begin
            state     <= BUSY;
            // Store wins when both type bits are set.
            req.rd    <= ~store;
            req.wr    <= store;
            req.addr  <= word_addr(addr);
            req.wdata <= al_wdata;
            req.mbe   <= al_mbe;
          end else if (misaligned) begin
            mbe_out <= '0;
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            state  <= DONE;
            req.rd <= 1'b0;
            req.wr <= 1'b0;
            tcnt   <= '0;
            if (req.rd) begin
              rdata_out <= dmem_rdata;
            end
            mbe_out <= req.mbe;
          end else begin
            if (tcnt != '1) begin
              tcnt <= tcnt + 1'b1;
            end
            if (T_EN && (tcnt == T_LAST)) begin
              timeout_err <= 1'b1;
            end
          end
        end
        DONE: begin
          if (advance) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: stimulus pushes expected requests,
// a negedge monitor pops and checks requests, stall length and captures.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        load;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        advance;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        mem_stall;
  logic [31:0] rdata_out;
  logic [3:0]  mbe_out;
  logic        misaligned;
  logic        timeout_err;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .load         (load),
    .store        (store),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .advance      (advance),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_mbe     (dmem_mbe),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .mem_stall    (mem_stall),
    .rdata_out    (rdata_out),
    .mbe_out      (mbe_out),
    .misaligned   (misaligned),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    int          hold;
    int          stall;
    logic [31:0] rdata;
    logic [3:0]  mbe_o;
  } exp_t;

  exp_t sb[$];
  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_rd = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor
  exp_t cur;
  bit   active = 1'b0;
  bit   req_prev = 1'b0;
  bit   stall_prev = 1'b0;
  bit   req_now;
  int   hold_cnt = 0;
  int   stall_cnt = 0;
  int   n_sb;

  always @(negedge clk) begin
    req_now = (dmem_read | dmem_write) === 1'b1;
    if (req_now && !req_prev) begin
      n_sb = sb.size();
      chk("req_expected", 32'(n_sb != 0), 32'd1);
      if (n_sb != 0) begin
        cur = sb.pop_front();
        active = 1'b1;
        hold_cnt = 0;
        chk("req_write", 32'(dmem_write), 32'(cur.wr));
        chk("req_read", 32'(dmem_read), 32'(!cur.wr));
        chk("req_addr", dmem_address, cur.addr);
        chk("req_mbe", 32'(dmem_mbe), 32'(cur.mbe));
        chk("req_wdata", dmem_wdata, cur.wdata);
      end
    end
    if (req_now) begin
      hold_cnt++;
      if (active) begin
        chk("req_stable_addr", dmem_address, cur.addr);
      end
    end
    if (!req_now && req_prev && active) begin
      chk("req_hold", hold_cnt, cur.hold);
    end
    if (mem_stall === 1'b1) begin
      stall_cnt++;
    end else begin
      if (stall_prev && active) begin
        chk("stall_len", stall_cnt, cur.stall);
        chk("rdata_out", rdata_out, cur.rdata);
        chk("mbe_out", 32'(mbe_out), 32'(cur.mbe_o));
        active = 1'b0;
      end
      stall_cnt = 0;
    end
    req_prev = req_now;
    stall_prev = (mem_stall === 1'b1);
  end

  task automatic access(input logic ld, input logic st,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] sd,
                        input int lat,
                        input logic [31:0] rd,
                        input logic [3:0] mbe_e,
                        input logic [31:0] wd_e,
                        input int hold_done);
    exp_t e;
    if (ld && !st) exp_rd = rd;
    e = '{wr: st, addr: {a[31:2], 2'b00}, mbe: mbe_e,
          wdata: wd_e, hold: lat, stall: lat + 1,
          rdata: exp_rd, mbe_o: mbe_e};
    sb.push_back(e);
    @(posedge clk); #1;
    valid_in = 1'b1; load = ld; store = st;
    funct3 = f3; addr = a; store_data = sd;
    advance = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
    end
    dmem_resp = 1'b1; dmem_rdata = rd;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    for (int i = 0; i < hold_done; i++) begin
      @(negedge clk);
      chk("done_stall", 32'(mem_stall), 32'd0);
      chk("done_noreq", 32'(dmem_read | dmem_write), 32'd0);
      chk("done_rdata", rdata_out, exp_rd);
      chk("done_mbe", 32'(mbe_out), 32'(mbe_e));
      @(posedge clk); #1;
    end
    advance = 1'b1;
    @(posedge clk); #1;
    advance = 1'b0; valid_in = 1'b0;
    load = 1'b0; store = 1'b0;
  endtask

  task automatic misal(input logic [2:0] f3,
                       input logic [31:0] a);
    @(posedge clk); #1;
    valid_in = 1'b1; load = 1'b1; store = 1'b0;
    funct3 = f3; addr = a; store_data = '0;
    advance = 1'b1;
    @(negedge clk);
    chk("misaligned", 32'(misaligned), 32'd1);
    chk("misal_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    valid_in = 1'b0; load = 1'b0; advance = 1'b0;
    @(negedge clk);
    chk("misal_mbe_out", 32'(mbe_out), 32'd0);
    chk("misal_noreq", 32'(dmem_read | dmem_write), 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; load = 1'b0; store = 1'b0;
    funct3 = '0; addr = '0; store_data = '0; advance = 1'b0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_read", 32'(dmem_read), 32'd0);
    chk("rst_write", 32'(dmem_write), 32'd0);
    chk("rst_addr", dmem_address, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_mbe", 32'(dmem_mbe), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_mbe_out", 32'(mbe_out), 32'd0);
    chk("rst_misal", 32'(misaligned), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);

    // lw, immediate response
    access(1, 0, 3'b010, 32'h100, 32'h0, 1,
           32'hDEADBEEF, 4'b1111, 32'h0, 0);
    // sb to top lane, 4-cycle cache latency
    access(0, 1, 3'b000, 32'h203, 32'h000000A5, 4,
           32'h0, 4'b1000, 32'hA5000000, 0);
    // lh upper half
    access(1, 0, 3'b001, 32'h102, 32'h0, 2,
           32'hBEEF0000, 4'b1100, 32'h0, 0);
    misal(3'b001, 32'h101);
    misal(3'b010, 32'h102);
    misal(3'b011, 32'h100);
    // sh upper half
    access(0, 1, 3'b001, 32'h302, 32'h1234ABCD, 3,
           32'h0, 4'b1100, 32'hABCD0000, 0);
    // load+store together acts as a store
    access(1, 1, 3'b010, 32'h500, 32'hCAFEF00D, 1,
           32'h11111111, 4'b1111, 32'hCAFEF00D, 0);
    // lbu, then hold DONE for 3 cycles
    access(1, 0, 3'b100, 32'h001, 32'h0, 2,
           32'h0000AB00, 4'b0010, 32'h0, 3);
    // back-to-back lb right after advance
    access(1, 0, 3'b000, 32'h003, 32'h0, 1,
           32'h7F000000, 4'b1000, 32'h0, 0);

    // reset in BUSY, late response discarded
    exp_rd = '0;
    sb.push_back('{wr: 1'b0, addr: 32'h400, mbe: 4'b1111,
                   wdata: 32'h0, hold: 1, stall: 2,
                   rdata: 32'h0, mbe_o: 4'b0000});
    @(posedge clk); #1;
    valid_in = 1'b1; load = 1'b1; funct3 = 3'b010;
    addr = 32'h400; store_data = '0;
    @(posedge clk); #1;
    rst = 1'b1; valid_in = 1'b0; load = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    @(negedge clk);
    chk("late_resp_rdata", rdata_out, 32'h0);
    chk("late_resp_mbe", 32'(mbe_out), 32'd0);
    chk("late_resp_addr", dmem_address, 32'h0);
    chk("late_resp_stall", 32'(mem_stall), 32'd0);

    // timeout with TIMEOUT_CYCLES=8, valid_in drops mid-BUSY
    chk("tmo_pre", 32'(timeout_err), 32'd0);
    exp_rd = 32'h600DCAFE;
    sb.push_back('{wr: 1'b0, addr: 32'h600, mbe: 4'b1111,
                   wdata: 32'h0, hold: 12, stall: 13,
                   rdata: 32'h600DCAFE, mbe_o: 4'b1111});
    @(posedge clk); #1;
    valid_in = 1'b1; load = 1'b1; funct3 = 3'b010;
    addr = 32'h600; store_data = '0;
    @(posedge clk); #1;
    for (int k = 1; k < 12; k++) begin
      if (k == 2) valid_in = 1'b0;
      @(negedge clk);
      if (k == 8) chk("tmo_busy8", 32'(timeout_err), 32'd0);
      if (k == 9) chk("tmo_busy9", 32'(timeout_err), 32'd1);
      @(posedge clk); #1;
    end
    dmem_resp = 1'b1; dmem_rdata = 32'h600DCAFE;
    @(posedge clk); #1;
    dmem_resp = 1'b0; advance = 1'b1;
    @(posedge clk); #1;
    advance = 1'b0; load = 1'b0;
    @(negedge clk);
    chk("tmo_sticky", 32'(timeout_err), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("tmo_rst", 32'(timeout_err), 32'd0);

    repeat (3) @(posedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule
